// File: rtl/pld_upsizer_pkg.sv
// Shared definitions for the narrow-to-wide payload packer (pld_upsizer).
// Optional packet framing is enabled with the PLD_UPSIZER_LAST_EN macro.
package pld_upsizer_pkg;

  localparam int unsigned PLD_WIDTH_DEF = 32;
  localparam int unsigned RATIO_DEF     = 4;

  // True when the lane counter currently points at the given lane.
  function automatic logic lane_hit(input int unsigned cnt, input int unsigned lane);
    return cnt == lane;
  endfunction

endpackage

// File: rtl/pld_upsizer_acc.sv
// Accumulator for pld_upsizer: lane counter, lane write decode and lane storage.
// With PLD_UPSIZER_LAST_EN defined, s_last flushes a partial group and a keep mask is produced.
module pld_upsizer_acc
  import pld_upsizer_pkg::*;
#(
  parameter int unsigned PLD_WIDTH = PLD_WIDTH_DEF,
  parameter int unsigned RATIO     = RATIO_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         accept,
  input  logic [PLD_WIDTH-1:0]         s_pld,
`ifdef PLD_UPSIZER_LAST_EN
  input  logic                         last,
  output logic [RATIO-1:0]             keep,
`endif
  output logic                         complete,
  output logic [PLD_WIDTH*RATIO-1:0]   wide
);

  localparam int unsigned CNT_W = $clog2(RATIO);

  typedef logic [PLD_WIDTH-1:0] pld_t;

  pld_t [RATIO-1:0] acc_q;
  pld_t [RATIO-1:0] merged;
  logic [CNT_W-1:0] cnt_q;
  logic [RATIO-1:0] lane_we;
  logic             at_end;

  // Merged word carries the beat being accepted now, so a completing beat
  // can be forwarded without first landing in acc_q.
  always_comb begin
    at_end = (cnt_q == CNT_W'(RATIO - 1));
`ifdef PLD_UPSIZER_LAST_EN
    complete = accept && (at_end || last);
`else
    complete = accept && at_end;
`endif
    for (int unsigned i = 0; i < RATIO; i++) begin
      lane_we[i] = accept && lane_hit(32'(cnt_q), i);
      merged[i]  = lane_we[i] ? s_pld : acc_q[i];
    end
  end

`ifdef PLD_UPSIZER_LAST_EN
  always_comb begin
    for (int unsigned i = 0; i < RATIO; i++) begin
      keep[i] = (i <= 32'(cnt_q));
    end
  end
`endif

  assign wide = merged;

  // Lanes are cleared on completion so unwritten lanes of a flushed group read as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else if (complete) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + CNT_W'(1);
      acc_q <= merged;
    end
  end

endmodule

// File: rtl/pld_upsizer.sv
// Packs RATIO consecutive PLD_WIDTH beats into one wide beat on a vld/rdy stream.
// Define PLD_UPSIZER_LAST_EN to add s_last/m_keep/m_last packet framing.
module pld_upsizer
  import pld_upsizer_pkg::*;
#(
  parameter int unsigned PLD_WIDTH = PLD_WIDTH_DEF,
  parameter int unsigned RATIO     = RATIO_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_vld,
  input  logic [PLD_WIDTH-1:0]         s_pld,
`ifdef PLD_UPSIZER_LAST_EN
  input  logic                         s_last,
  output logic [RATIO-1:0]             m_keep,
  output logic                         m_last,
`endif
  output logic                         s_rdy,
  output logic                         m_vld,
  output logic [PLD_WIDTH*RATIO-1:0]   m_pld,
  input  logic                         m_rdy
);

  logic                       accept;
  logic                       complete;
  logic [PLD_WIDTH*RATIO-1:0] wide;
`ifdef PLD_UPSIZER_LAST_EN
  logic [RATIO-1:0]           keep;
`endif

  // m_rdy reaches s_rdy combinationally; the downstream register slice cuts that path.
  assign s_rdy  = !m_vld || m_rdy;
  assign accept = s_vld && s_rdy;

  pld_upsizer_acc #(
    .PLD_WIDTH (PLD_WIDTH),
    .RATIO     (RATIO)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .accept   (accept),
    .s_pld    (s_pld),
`ifdef PLD_UPSIZER_LAST_EN
    .last     (s_last),
    .keep     (keep),
`endif
    .complete (complete),
    .wide     (wide)
  );

  // A completing accept reloads the output even while it is being drained,
  // giving back-to-back wide beats with no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_vld  <= 1'b0;
      m_pld  <= '0;
`ifdef PLD_UPSIZER_LAST_EN
      m_keep <= '0;
      m_last <= 1'b0;
`endif
    end else if (complete) begin
      m_vld  <= 1'b1;
      m_pld  <= wide;
`ifdef PLD_UPSIZER_LAST_EN
      m_keep <= keep;
      m_last <= s_last;
`endif
    end else if (m_vld && m_rdy) begin
      m_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pld_upsizer.sv
// Directed testbench for pld_upsizer (PLD_WIDTH=32, RATIO=4), built with or without
// PLD_UPSIZER_LAST_EN.
module tb_pld_upsizer;

  localparam int unsigned PW = 32;
  localparam int unsigned R  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           s_vld;
  logic [PW-1:0]  s_pld;
  logic           s_rdy;
  logic           m_vld;
  logic [PW*R-1:0] m_pld;
  logic           m_rdy;
`ifdef PLD_UPSIZER_LAST_EN
  logic           s_last;
  logic [R-1:0]   m_keep;
  logic           m_last;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  pld_upsizer #(
    .PLD_WIDTH (PW),
    .RATIO     (R)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_vld  (s_vld),
    .s_pld  (s_pld),
`ifdef PLD_UPSIZER_LAST_EN
    .s_last (s_last),
    .m_keep (m_keep),
    .m_last (m_last),
`endif
    .s_rdy  (s_rdy),
    .m_vld  (m_vld),
    .m_pld  (m_pld),
    .m_rdy  (m_rdy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic vld, input logic [PW-1:0] pld, input logic rdy);
    s_vld = vld;
    s_pld = pld;
    m_rdy = rdy;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [PW*R-1:0] obs,
                             input logic [PW*R-1:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst   = 1'b1;
    s_vld = 1'b1;
    s_pld = 32'hDEADBEEF;
    m_rdy = 1'b1;
`ifdef PLD_UPSIZER_LAST_EN
    s_last = 1'b0;
`endif
    $display("[TB] reset with s_vld held high");
    tick();
    tick();
    checkOutput("rst_m_vld", 128'(m_vld), 128'(0));
    checkOutput("rst_m_pld", m_pld, 128'(0));
    checkOutput("rst_s_rdy", 128'(s_rdy), 128'(1));
`ifdef PLD_UPSIZER_LAST_EN
    checkOutput("rst_m_keep", 128'(m_keep), 128'(0));
    checkOutput("rst_m_last", 128'(m_last), 128'(0));
`endif
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1);

    $display("[TB] streaming 1..8");
    for (int i = 1; i <= 8; i++) begin
      checkOutput("stream_s_rdy", 128'(s_rdy), 128'(1));
      applyStimulus(1'b1, 32'(i), 1'b1);
      checkOutput("stream_m_vld", 128'(m_vld), 128'((i % 4) == 0));
      if (i == 4)
        checkOutput("stream_grp0", m_pld, 128'h00000004_00000003_00000002_00000001);
      if (i == 8)
        checkOutput("stream_grp1", m_pld, 128'h00000008_00000007_00000006_00000005);
    end

    $display("[TB] backpressure");
    s_vld = 1'b1;
    s_pld = 32'h9;
    m_rdy = 1'b0;
    #1;
    checkOutput("bp_s_rdy_low", 128'(s_rdy), 128'(0));
    tick();
    checkOutput("bp_m_vld_hold", 128'(m_vld), 128'(1));
    checkOutput("bp_m_pld_hold", m_pld, 128'h00000008_00000007_00000006_00000005);
    s_pld = 32'hA;
    tick();
    checkOutput("bp_m_pld_hold2", m_pld, 128'h00000008_00000007_00000006_00000005);
    checkOutput("bp_s_rdy_low2", 128'(s_rdy), 128'(0));
    applyStimulus(1'b1, 32'h9, 1'b1);
    checkOutput("bp_drained", 128'(m_vld), 128'(0));
    applyStimulus(1'b1, 32'hA, 1'b1);
    applyStimulus(1'b1, 32'hB, 1'b1);
    applyStimulus(1'b1, 32'hC, 1'b1);
    checkOutput("bp_resume_vld", 128'(m_vld), 128'(1));
    checkOutput("bp_resume_pld", m_pld, 128'h0000000c_0000000b_0000000a_00000009);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("bp_consumed", 128'(m_vld), 128'(0));

`ifdef PLD_UPSIZER_LAST_EN
    $display("[TB] simultaneous load and drain");
    s_last = 1'b1;
    applyStimulus(1'b1, 32'h21, 1'b1);
    checkOutput("sim_vld0", 128'(m_vld), 128'(1));
    checkOutput("sim_pld0", m_pld, 128'h00000000_00000000_00000000_00000021);
    checkOutput("sim_keep0", 128'(m_keep), 128'(4'b0001));
    checkOutput("sim_last0", 128'(m_last), 128'(1));
    applyStimulus(1'b1, 32'h22, 1'b1);
    checkOutput("sim_vld1", 128'(m_vld), 128'(1));
    checkOutput("sim_pld1", m_pld, 128'h00000000_00000000_00000000_00000022);

    $display("[TB] flush on s_last");
    s_last = 1'b0;
    applyStimulus(1'b1, 32'hA, 1'b1);
    checkOutput("flush_vld_a", 128'(m_vld), 128'(0));
    s_last = 1'b1;
    applyStimulus(1'b1, 32'hB, 1'b1);
    checkOutput("flush_vld", 128'(m_vld), 128'(1));
    checkOutput("flush_pld", m_pld, 128'h00000000_00000000_0000000b_0000000a);
    checkOutput("flush_keep", 128'(m_keep), 128'(4'b0011));
    checkOutput("flush_last", 128'(m_last), 128'(1));
    s_last = 1'b0;
    applyStimulus(1'b1, 32'hC, 1'b1);
    applyStimulus(1'b1, 32'hD, 1'b1);
    applyStimulus(1'b1, 32'hE, 1'b1);
    applyStimulus(1'b1, 32'hF, 1'b1);
    checkOutput("full_pld", m_pld, 128'h0000000f_0000000e_0000000d_0000000c);
    checkOutput("full_keep", 128'(m_keep), 128'(4'b1111));
    checkOutput("full_last", 128'(m_last), 128'(0));
`endif

    $display("[TB] mid-packet reset");
    applyStimulus(1'b1, 32'h31, 1'b1);
    applyStimulus(1'b1, 32'h32, 1'b1);
    rst   = 1'b1;
    s_vld = 1'b0;
    tick();
    checkOutput("mrst_m_vld", 128'(m_vld), 128'(0));
    checkOutput("mrst_m_pld", m_pld, 128'(0));
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'(32'h41 + i), 1'b1);
      checkOutput("mrst_m_vld_grp", 128'(m_vld), 128'(i == 3));
    end
    checkOutput("mrst_pld", m_pld, 128'h00000044_00000043_00000042_00000041);
`ifdef PLD_UPSIZER_LAST_EN
    checkOutput("mrst_keep", 128'(m_keep), 128'(4'b1111));
`endif
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("end_drained", 128'(m_vld), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
